// File: rtl/audio_pkg.sv
// Shared audio types: note index, rest marker, half-period table
// and the tone FSM state encoding.
package audio_pkg;

    typedef logic [3:0] note_t;

    localparam note_t REST = 4'hF;

    // Half-period in 50 MHz cycles; the rest slot only keeps the counter bounded
    localparam logic [16:0] HALF_PERIOD [16] = '{
        17'd95556, 17'd85131, 17'd75843, 17'd71586,
        17'd63776, 17'd56818, 17'd50619, 17'd47778,
        17'd42566, 17'd37922, 17'd35793, 17'd31888,
        17'd28409, 17'd25310, 17'd23889, 17'h1FFFF
    };

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GAP  = 2'd1,
        S_PLAY = 2'd2
    } state_t;

endpackage

// File: rtl/tone_generator.sv
// Square-wave / PCM tone generator driven by a note sequencer,
// with a short silent gap inserted between distinct notes.
module tone_generator
    import audio_pkg::*;
#(
    parameter int                 GAP_CYCLES = 500000,
    parameter logic signed [15:0] AMPLITUDE  = 16'sd8000
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic [3:0]         frequency,
    input  logic               enable,
    output logic               audio_out,
    output logic signed [15:0] sample,
    output logic               playing
);

    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    state_t          state;
    note_t           cur_note;
    logic [16:0]     half_cnt;
    logic [GW-1:0]   gap_cnt;
    logic            phase;
    logic            sounding;
    logic [16:0]     half_last;

    assign half_last = HALF_PERIOD[cur_note] - 17'd1;
    assign sounding  = (state == S_PLAY) && (cur_note != REST);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state    <= S_IDLE;
            cur_note <= '0;
            half_cnt <= '0;
            gap_cnt  <= '0;
            phase    <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (enable) begin
                        cur_note <= frequency;
                        half_cnt <= '0;
                        phase    <= 1'b1;
                        state    <= S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (!enable) begin
                        state <= S_IDLE;
                    end else if (frequency != cur_note) begin
                        cur_note <= frequency;
                        gap_cnt  <= '0;
                        state    <= S_GAP;
                    end else if (half_cnt == half_last) begin
                        half_cnt <= '0;
                        phase    <= ~phase;
                    end else begin
                        half_cnt <= half_cnt + 17'd1;
                    end
                end
                S_GAP: begin
                    if (!enable) begin
                        state <= S_IDLE;
                    end else if (frequency != cur_note) begin
                        cur_note <= frequency;
                        gap_cnt  <= '0;
                    end else if (gap_cnt == GAP_LAST) begin
                        half_cnt <= '0;
                        phase    <= 1'b1;
                        state    <= S_PLAY;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            audio_out <= 1'b0;
            sample    <= '0;
            playing   <= 1'b0;
        end else begin
            audio_out <= sounding & phase;
            playing   <= sounding;
            if (!sounding)
                sample <= '0;
            else if (phase)
                sample <= AMPLITUDE;
            else
                sample <= -AMPLITUDE;
        end
    end

endmodule
